sipo_capture_ctrl: RTL and testbench

Sequencing controller for the 8-bit serial-in/parallel-out shift register (ports sin, clk, rs, PO).
- On a start request, clears the register, issues exactly WIDTH shift-enable pulses at a programmable bit rate, then captures the parallel word into a holding register.
- Presents the captured word to a downstream consumer over a valid/ready handshake, with sticky overrun reporting.

---
 rtl/sipo_capture_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_sipo_capture_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_capture_ctrl
//  Description : Sequencing controller for an external serial-in/parallel-out
//                shift register. A start request clears the register, issues
//                exactly WIDTH shift-enable pulses (one every DIV clocks), then
//                captures the parallel word into a holding register. The word
//                is offered downstream over valid/ready. A frame that cannot
//                be stored because the previous word is still pending raises
//                a sticky overrun flag.
//  Optional    : `define PARITY_CHECK_EN adds one parity bit period after the
//                data bits; sin is sampled mid-frame-end and parity_err
//                reports an even-parity violation for the captured word.
//  Ports       : clk        - system clock, rising edge
//                rs         - asynchronous reset, active-low
//                start      - frame request, honoured only in IDLE
//                sin        - serial line (parity sampling only)
//                po         - parallel output of the shift register
//                sr_clr     - synchronous clear to the shift register
//                shift_en   - shift enable to the shift register
//                busy       - controller is not in IDLE
//                dout       - captured word, stable while dout_valid=1
//                dout_valid - captured word available
//                dout_ready - consumer accepts dout on valid&ready
//                parity_err - parity result for dout (qualified by dout_valid)
//                overrun    - sticky, a frame was dropped
//                clr_ovr    - synchronous clear of overrun
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_capture_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             start,
  input  logic             sin,
  input  logic [WIDTH-1:0] po,
  output logic             sr_clr,
  output logic             shift_en,
  output logic             busy,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             parity_err,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SHIFT  = 3'd2,
    S_LOAD   = 3'd3
`ifdef PARITY_CHECK_EN
    ,
    S_PARITY = 3'd4
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overrun;
  logic             w_div_last;
  logic             w_load;
  logic             w_accept;

  // Last cycle of a bit period; constant 1 when DIV=1.
  assign w_div_last = (r_div_cnt == c_div_last);
  assign w_load     = (r_state == S_LOAD);
  // A new word may be stored if the slot is empty or is being drained now.
  assign w_accept   = !r_dout_valid || dout_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and Moore outputs (decoded from registered state/counters)
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    sr_clr      = 1'b0;
    shift_en    = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        sr_clr      = 1'b1;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        shift_en = w_div_last;
        if (w_div_last && (r_bit_cnt == c_bit_last)) begin
`ifdef PARITY_CHECK_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_LOAD;
`endif
        end
      end
`ifdef PARITY_CHECK_EN
      S_PARITY: begin
        if (w_div_last) begin
          w_state_nxt = S_LOAD;
        end
      end
`endif
      S_LOAD: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Bit-rate divider and bit counter; both idle at zero outside their states
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
`ifdef PARITY_CHECK_EN
      if ((r_state == S_SHIFT) || (r_state == S_PARITY)) begin
`else
      if (r_state == S_SHIFT) begin
`endif
        r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
      end else begin
        r_div_cnt <= '0;
      end

      if (r_state == S_SHIFT) begin
        if (w_div_last) begin
          r_bit_cnt <= (r_bit_cnt == c_bit_last) ? '0 : r_bit_cnt + 1'b1;
        end
      end else begin
        r_bit_cnt <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Holding register, handshake and sticky overrun
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_load && w_accept) begin
        r_dout       <= po;
        r_dout_valid <= 1'b1;
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end

      // Setting has priority over a simultaneous clear.
      if (w_load && !w_accept) begin
        r_overrun <= 1'b1;
      end else if (clr_ovr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign overrun    = r_overrun;

`ifdef PARITY_CHECK_EN
  logic r_par_bit;
  logic r_parity_err;

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if ((r_state == S_PARITY) && w_div_last) begin
        r_par_bit <= sin;
      end
      // Even parity over data plus parity bit; nonzero means an error.
      if (w_load && w_accept) begin
        r_parity_err <= (^po) ^ r_par_bit;
      end
    end
  end

  assign parity_err = r_parity_err;
`else
  logic w_unused_sin;
  assign w_unused_sin = sin;
  assign parity_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sipo_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sipo_capture_ctrl
//  Description : Directed self-checking bench for sipo_capture_ctrl. Two
//                instances (DIV=1 and DIV=4) each drive a behavioural 8-bit
//                shift register whose serial input is fed from a frame word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_capture_ctrl;

`ifdef PARITY_CHECK_EN
  localparam int LAT0 = 11;
  localparam int LAT1 = 38;
`else
  localparam int LAT0 = 10;
  localparam int LAT1 = 34;
`endif

  logic       clk = 1'b0;
  logic       rs  = 1'b0;
  always #5 clk = ~clk;

  // Instance 0 (DIV=1)
  logic       start0 = 0, ready0 = 0, clr0 = 0;
  logic       sin0, sr_clr0, shift_en0, busy0, valid0, perr0, ovr0;
  logic [7:0] po0, dout0;
  logic [7:0] frame0 = 8'h00;
  logic       par0   = 1'b0;
  int         k0;

  // Instance 1 (DIV=4)
  logic       start1 = 0, ready1 = 0, clr1 = 0;
  logic       sin1, sr_clr1, shift_en1, busy1, valid1, perr1, ovr1;
  logic [7:0] po1, dout1;
  logic [7:0] frame1 = 8'h00;
  logic       par1   = 1'b0;
  int         k1;

  int total  = 0;
  int passed = 0;

  sipo_capture_ctrl #(.WIDTH(8), .DIV(1)) u_dut0 (
    .clk(clk), .rs(rs), .start(start0), .sin(sin0), .po(po0),
    .sr_clr(sr_clr0), .shift_en(shift_en0), .busy(busy0), .dout(dout0),
    .dout_valid(valid0), .dout_ready(ready0), .parity_err(perr0),
    .overrun(ovr0), .clr_ovr(clr0)
  );

  sipo_capture_ctrl #(.WIDTH(8), .DIV(4)) u_dut1 (
    .clk(clk), .rs(rs), .start(start1), .sin(sin1), .po(po1),
    .sr_clr(sr_clr1), .shift_en(shift_en1), .busy(busy1), .dout(dout1),
    .dout_valid(valid1), .dout_ready(ready1), .parity_err(perr1),
    .overrun(ovr1), .clr_ovr(clr1)
  );

  // Shift-register models: po <= {po[6:0], sin}; sin is the frame MSB-first,
  // then the parity bit once all data bits have been shifted.
  assign sin0 = (k0 < 8) ? frame0[7-k0] : par0;
  assign sin1 = (k1 < 8) ? frame1[7-k1] : par1;

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      po0 <= '0; k0 <= 0; po1 <= '0; k1 <= 0;
    end else begin
      if (sr_clr0) begin
        po0 <= '0; k0 <= 0;
      end else if (shift_en0) begin
        po0 <= {po0[6:0], sin0}; k0 <= k0 + 1;
      end
      if (sr_clr1) begin
        po1 <= '0; k1 <= 0;
      end else if (shift_en1) begin
        po1 <= {po1[6:0], sin1}; k1 <= k1 + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Runs one frame on instance dsel. Starts at a negedge; edge 0 is the next
  // posedge. Returns the edge index after which busy fell (== dout_valid edge),
  // shift/clear pulse counts and min/max spacing between shift pulses.
  // ready_at >= 0 raises dout_ready for exactly the cycle after that edge.
  task automatic run_frame(input int dsel, input logic [7:0] data, input logic pbit,
                           input int ready_at, output int lat, output int shifts,
                           output int clrs, output int min_gap, output int max_gap);
    int n, last;
    logic rdy_set;
    n = 0; last = -1; shifts = 0; clrs = 0; min_gap = 1000; max_gap = 0;
    rdy_set = 1'b0;
    if (dsel == 0) begin frame0 = data; par0 = pbit; start0 = 1'b1; end
    else           begin frame1 = data; par1 = pbit; start1 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    if ((dsel == 0) ? sr_clr0 : sr_clr1) clrs++;
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (rdy_set) begin
        if (dsel == 0) ready0 = 1'b0; else ready1 = 1'b0;
        rdy_set = 1'b0;
      end
      // A mid-frame start request must be ignored.
      if (n == 4) begin
        if (dsel == 0) start0 = 1'b1; else start1 = 1'b1;
      end
      if (n == 5) begin
        start0 = 1'b0; start1 = 1'b0;
      end
      if ((dsel == 0) ? sr_clr0 : sr_clr1) clrs++;
      if ((dsel == 0) ? shift_en0 : shift_en1) begin
        shifts++;
        if (last >= 0) begin
          if (n - last < min_gap) min_gap = n - last;
          if (n - last > max_gap) max_gap = n - last;
        end
        last = n;
      end
      if (!((dsel == 0) ? busy0 : busy1)) break;
      if (n == ready_at) begin
        if (dsel == 0) ready0 = 1'b1; else ready1 = 1'b1;
        rdy_set = 1'b1;
      end
    end
    lat = n;
  endtask

  initial begin
    int lat, sh, cl, gmin, gmax;

    // ---------------- Reset state ----------------
    @(negedge clk);
    @(negedge clk);
    check("reset_outs0", {dout0, valid0, perr0, ovr0, busy0, sr_clr0, shift_en0}, 32'h0);
    check("reset_outs1", {dout1, valid1, perr1, ovr1, busy1, sr_clr1, shift_en1}, 32'h0);
    rs = 1'b1;
    @(negedge clk);

    // ---------------- Basic frame, DIV=1 ----------------
    run_frame(0, 8'hE9, 1'b1, -1, lat, sh, cl, gmin, gmax);
    check("basic_latency", lat, LAT0);
    check("basic_shifts", sh, 8);
    check("basic_clrs", cl, 1);
    check("basic_gap", {gmin[15:0], gmax[15:0]}, {16'd1, 16'd1});
    check("basic_dout", dout0, 8'hE9);
    check("basic_valid", valid0, 1'b1);
    check("basic_ovr", ovr0, 1'b0);
    @(negedge clk);
    check("start_not_queued", busy0, 1'b0);

    // ---------------- Bit rate, DIV=4 ----------------
    run_frame(1, 8'hE9, 1'b1, -1, lat, sh, cl, gmin, gmax);
    check("div4_latency", lat, LAT1);
    check("div4_shifts", sh, 8);
    check("div4_gap", {gmin[15:0], gmax[15:0]}, {16'd4, 16'd4});
    check("div4_dout", {valid1, dout1}, {1'b1, 8'hE9});

    // ---------------- Reset mid-frame ----------------
    frame0 = 8'h17;
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    sh = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (shift_en0) sh++;
      if (sh == 4) break;
    end
    check("midrst_reached4", sh, 4);
    rs = 1'b0;
    #1;
    check("midrst_outs", {dout0, valid0, perr0, ovr0, busy0, sr_clr0, shift_en0}, 32'h0);
    @(negedge clk);
    rs = 1'b1;
    @(negedge clk);
    run_frame(0, 8'hE9, 1'b1, -1, lat, sh, cl, gmin, gmax);
    check("postrst_shifts", sh, 8);
    check("postrst_clrs", cl, 1);
    check("postrst_dout", {valid0, dout0}, {1'b1, 8'hE9});

    // ---------------- Backpressure / overrun ----------------
    run_frame(0, 8'h17, 1'b1, -1, lat, sh, cl, gmin, gmax);
    check("ovr_dout_held", dout0, 8'hE9);
    check("ovr_valid", valid0, 1'b1);
    check("ovr_set", ovr0, 1'b1);
    @(negedge clk);
    check("ovr_sticky", ovr0, 1'b1);
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    check("ovr_cleared", ovr0, 1'b0);
    ready0 = 1'b1;
    @(negedge clk);
    ready0 = 1'b0;
    check("ready_drains", valid0, 1'b0);

    // ---------------- Simultaneous accept in LOAD ----------------
    run_frame(0, 8'hE9, 1'b1, -1, lat, sh, cl, gmin, gmax);
    check("sim_first", {valid0, dout0}, {1'b1, 8'hE9});
    run_frame(0, 8'h17, 1'b0, LAT0 - 1, lat, sh, cl, gmin, gmax);
    check("sim_dout", dout0, 8'h17);
    check("sim_valid", valid0, 1'b1);
    check("sim_no_ovr", ovr0, 1'b0);
    ready0 = 1'b1;
    @(negedge clk);
    ready0 = 1'b0;
    check("sim_drained", valid0, 1'b0);

    // ---------------- Parity ----------------
`ifdef PARITY_CHECK_EN
    run_frame(0, 8'hE9, 1'b1, -1, lat, sh, cl, gmin, gmax);
    check("par_latency", lat, 11);
    check("par_good", {valid0, perr0}, {1'b1, 1'b0});
    ready0 = 1'b1;
    @(negedge clk);
    ready0 = 1'b0;
    run_frame(0, 8'hE9, 1'b0, -1, lat, sh, cl, gmin, gmax);
    check("par_bad", {valid0, perr0}, {1'b1, 1'b1});
    check("par_bad_dout", dout0, 8'hE9);
`else
    run_frame(0, 8'hE9, 1'b0, -1, lat, sh, cl, gmin, gmax);
    check("par_off_latency", lat, 10);
    check("par_off_tied", {valid0, perr0}, {1'b1, 1'b0});
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
